// File: rtl/frequency_meter.sv
`default_nettype none
// ============================================================================
// Module   : frequency_meter
// Purpose  : Measures the frequency of an asynchronous input by counting its
//            synchronised rising edges over back-to-back gate windows of
//            GATE_CYCLES board-clock cycles. Each completed window reports its
//            edge count, saturated to COUNT_BITS, along with a one-cycle valid
//            pulse and a sticky-per-window overflow flag.
// Ports    : clk          in   board clock, all state on rising edge
//            rst          in   synchronous active-high reset
//            enable       in   1 = measure continuously, 0 = idle
//            signalIn     in   signal under test, asynchronous to clk
//            frequencyOut out  edge count of the last completed window
//            valid        out  one-cycle pulse when frequencyOut updates
//            overflow     out  last completed window saturated the counter
// Revision : 1.0 - initial release
// ============================================================================
module frequency_meter #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int GATE_FREQUENCY_IN_HZ        = 1,
  parameter int COUNT_BITS                  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  signalIn,
  output logic [COUNT_BITS-1:0] frequencyOut,
  output logic                  valid,
  output logic                  overflow
);

  // Window length in board-clock cycles; must be at least 2.
  localparam int GATE_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ / GATE_FREQUENCY_IN_HZ;
  localparam int GATE_BITS   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [GATE_BITS-1:0]  GATE_LAST = GATE_BITS'(GATE_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e                state_q;
  logic                  sync1_q;
  logic                  sync2_q;
  logic                  prev_q;
  logic [GATE_BITS-1:0]  gate_q;
  logic [COUNT_BITS-1:0] edge_cnt_q;
  logic                  sat_q;
  logic [COUNT_BITS-1:0] freq_q;
  logic                  valid_q;
  logic                  ovf_q;

  logic                  edge_d;
  logic                  at_max_d;
  logic                  sat_attempt_d;
  logic [COUNT_BITS-1:0] edge_cnt_d;
  logic [GATE_BITS-1:0]  gate_d;

  // Saturating "edgeCount + edge": the same value serves as the running count
  // inside the window and as the result latched in the terminal cycle, so an
  // edge landing in the terminal cycle belongs to the ending window.
  always_comb begin
    edge_d        = sync2_q & ~prev_q;
    at_max_d      = (edge_cnt_q == COUNT_MAX);
    sat_attempt_d = edge_d & at_max_d;
    edge_cnt_d    = edge_cnt_q;
    if (edge_d && !at_max_d) begin
      edge_cnt_d = edge_cnt_q + COUNT_BITS'(1);
    end
    gate_d = gate_q + GATE_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // Synchroniser and history flop run regardless of state.
      sync1_q <= signalIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          gate_q     <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
          if (enable) begin
            state_q <= MEASURE;
          end
        end

        MEASURE: begin
          if (!enable) begin
            // Partial window is discarded; published results hold.
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end else if (gate_q == GATE_LAST) begin
            freq_q     <= edge_cnt_d;
            ovf_q      <= sat_q | sat_attempt_d;
            valid_q    <= 1'b1;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end else begin
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            if (sat_attempt_d) begin
              sat_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign frequencyOut = freq_q;
  assign valid        = valid_q;
  assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_frequency_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frequency_meter
// Purpose  : Self-checking bench for frequency_meter. Two instances (32-bit
//            and 2-bit counters, 100 Hz board clock, 10 Hz gate) share the
//            same stimulus; a window-level reference model predicts every
//            output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frequency_meter;

  localparam int G     = 10;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        signalIn;
  logic [31:0] f32;
  logic [1:0]  f2;
  logic        v32, o32, v2, o2;

  frequency_meter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(100),
    .GATE_FREQUENCY_IN_HZ       (10),
    .COUNT_BITS                 (32)
  ) dut32 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .signalIn    (signalIn),
    .frequencyOut(f32),
    .valid       (v32),
    .overflow    (o32)
  );

  frequency_meter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(100),
    .GATE_FREQUENCY_IN_HZ       (10),
    .COUNT_BITS                 (2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .signalIn    (signalIn),
    .frequencyOut(f2),
    .valid       (v2),
    .overflow    (o2)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: s[] holds the signal value captured by the first
  // synchroniser flop at each clock edge (0 while in reset). A window that
  // starts at edge ws and ends at edge ws+G counts the rising transitions
  // s[k-1]=0 -> s[k]=1 for k in ws-1 .. ws+G-2 (two-cycle input latency).
  bit          s [0:DEPTH-1];
  int          cyc  = 2;
  bit          meas = 1'b0;
  int          ws   = 0;
  logic [31:0] e_f32 = '0;
  logic [1:0]  e_f2  = '0;
  logic        e_o2  = 1'b0;
  logic        e_v   = 1'b0;

  function automatic int window_edges(input int start);
    int n = 0;
    for (int k = start - 1; k <= start + G - 2; k++) begin
      if (s[k] && !s[k-1]) n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic step(input bit r, input bit en, input bit sig);
    int n;
    rst      = r;
    enable   = en;
    signalIn = sig;
    @(posedge clk);
    if (cyc >= DEPTH - 1) begin
      $display("FAIL model_depth observed=%0d expected<%0d", cyc, DEPTH - 1);
      $fatal(1, "model history exhausted");
    end
    s[cyc] = r ? 1'b0 : sig;
    e_v    = 1'b0;
    if (r) begin
      meas  = 1'b0;
      e_f32 = '0;
      e_f2  = '0;
      e_o2  = 1'b0;
    end else if (!meas) begin
      if (en) begin
        meas = 1'b1;
        ws   = cyc;
      end
    end else if (!en) begin
      meas = 1'b0;
    end else if (cyc == ws + G) begin
      n     = window_edges(ws);
      e_f32 = 32'(n);
      e_f2  = (n > 3) ? 2'd3 : 2'(n);
      e_o2  = (n > 3);
      e_v   = 1'b1;
      ws    = cyc;
    end
    cyc++;
    #1;
    check("valid32", {31'd0, v32}, {31'd0, e_v});
    check("freq32",  f32, e_f32);
    check("ovf32",   {31'd0, o32}, 32'd0);
    check("valid2",  {31'd0, v2}, {31'd0, e_v});
    check("freq2",   {30'd0, f2}, {30'd0, e_f2});
    check("ovf2",    {31'd0, o2}, {31'd0, e_o2});
  endtask

  // Run enabled until the gate counter (cycles since window start) equals g.
  task automatic run_to_gate(input int g, input bit sig_toggle);
    bit sig = 1'b0;
    for (int i = 0; i < 3 * G; i++) begin
      if (meas && (cyc - 1 - ws) == g) break;
      if (sig_toggle) sig = ~sig;
      step(1'b0, 1'b1, sig);
    end
    check("gate_reached", {31'd0, meas && (cyc - 1 - ws) == g}, 32'd1);
  endtask

  initial begin
    int dens;
    bit sig;
    rst      = 1'b1;
    enable   = 1'b1;
    signalIn = 1'b0;

    // Reset held 3 cycles with enable high and a toggling input.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i[0]);

    // Nominal: period-5 input starting low.
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, (i % 5) >= 3);

    // Maximum rate: toggle every cycle (2-bit instance saturates).
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, i[0]);

    // Input low for more than a full window clears the overflow.
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0);

    // Abort at gateCount 6, then re-enable after a short idle gap.
    run_to_gate(6, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i[0]);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, (i % 3) == 0);

    // Mid-window reset at gateCount 4, then resume with input high.
    run_to_gate(4, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b1);

    // Randomised traffic: varying edge density, occasional enable drops
    // and resets.
    dens = 50;
    for (int i = 0; i < 900; i++) begin
      if (i % 40 == 0) dens = int'($urandom_range(0, 100));
      sig = ($urandom_range(0, 99) < dens);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0, sig);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frequency_meter.md
# frequency_meter

Measures the frequency of an asynchronous input by counting its rising edges over a fixed gate window derived from the board clock. It is the counterpart to the team's clock divider: the divider turns the board clock into a slow tick, and this block turns an external or derived signal back into a number in Hz. It feeds the stopwatch display and self-test path, which can check any divided clock against its programmed frequency.

## Interface
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, frequency of clk.
- GATE_FREQUENCY_IN_HZ, 1, windows per second. Window length GATE_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ / GATE_FREQUENCY_IN_HZ cycles (integer division, must be ≥ 2).
- COUNT_BITS, 32, width of the edge counter and result.

One clock; reset is synchronous and active-high.

- clk  in  1  board clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  high = measure continuously; low = idle.
- signalIn  in  1  signal under test, asynchronous to clk.
- frequencyOut  out  COUNT_BITS  edge count of the last completed window.
- valid  out  1  one-cycle pulse when frequencyOut updates.
- overflow  out  1  the last completed window saturated the counter; updates together with frequencyOut.

## Operation
- Input path:
  - Two-flop synchronizer sync1 → sync2, then history flop prev.
  - edge = sync2 & ~prev.
  - The edge detector runs in every state.
- The state machine has two states, IDLE and MEASURE.
  - IDLE: gateCount = 0, edgeCount = 0, no counting. If enable is high, go to MEASURE with gateCount = 0 and edgeCount = 0.
  - MEASURE, enable low: go to IDLE and clear both counters. The partial window is discarded: no valid pulse, and frequencyOut and overflow hold.
  - MEASURE, enable high, gateCount < GATE_CYCLES-1: gateCount increments. edgeCount increments on edge, saturating at 2^COUNT_BITS-1. A saturation attempt sets the internal sat flag.
  - MEASURE, enable high, gateCount == GATE_CYCLES-1 (terminal cycle):
    - frequencyOut ← edgeCount + edge, saturated.
    - overflow ← sat, or saturation in this cycle.
    - valid ← 1.
    - gateCount, edgeCount and sat ← 0. MEASURE continues.
    - Windows are back-to-back with no gap, and an edge in the terminal cycle belongs to the ending window.
- valid is low in every cycle other than the one after a terminal cycle.
- Reset:
  - sync1, sync2, prev, counters and sat are 0, and state is IDLE.
  - frequencyOut = 0, valid = 0, overflow = 0.
  - Reset in mid-window aborts the window with no valid pulse.
  - Because prev resets to 0, if signalIn is high at reset release and enable is high, one edge is counted. This is intended.
- Arithmetic:
  - All counts are unsigned.
  - gateCount is $clog2(GATE_CYCLES) bits wide and never wraps past GATE_CYCLES-1.
  - The maximum countable rate is one edge per 2 clk cycles, i.e. BOARD_CLOCK_FREQUENCY_IN_HZ/2. Faster inputs alias and are not flagged.

## Timing
- Edge latency: a signalIn rising edge first sampled at clk edge k is counted at clk edge k+2.
  - Window boundaries are therefore skewed by 2 cycles against signalIn.
  - Counts may differ by ±1 from the true value.
- Start: enable sampled high at edge t in IDLE.
  - The window occupies the cycles following edges t … t+G-1 (G = GATE_CYCLES).
  - Results are latched at edge t+G, and valid is high for the cycle following edge t+G.
  - Later results arrive every G cycles.
- Stop: enable sampled low at any edge in MEASURE gives IDLE after that edge. If that edge would have been terminal, no result is produced.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst for 3 cycles with enable = 1 and signalIn toggling -> frequencyOut = 0, valid = 0, overflow = 0 throughout reset. The first valid appears exactly G cycles after the edge where rst is first sampled low.
- Nominal (BOARD = 100, GATE = 10, so G = 10): enable = 1, signalIn period 5 cycles, started low -> every window after the first reports frequencyOut = 2, overflow = 0. valid is high for exactly 1 of every 10 cycles.
- Maximum rate (same params): signalIn toggles every cycle -> frequencyOut = 5 per steady-state window.
- Saturation (COUNT_BITS = 2, same params, toggle every cycle) -> frequencyOut = 3, overflow = 1. Then hold signalIn low for a full window -> frequencyOut = 0, overflow = 0.
- Abort: drop enable at gateCount = 6 -> no valid pulse, frequencyOut holds its previous value. Re-enable -> the next valid arrives G cycles after the re-enable edge.
- Mid-window reset: assert rst at gateCount = 4 -> all outputs 0 on the next cycle, and no valid pulse for the aborted window.
